// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream loader for the instruction memory
//
// Accepts a stream of: 2-byte word count N (LSB first), 4N payload bytes
// (little-endian words), 1 XOR checksum byte. Each assembled word goes to the
// instruction memory write port. The core is held in reset until the image
// has loaded and its checksum has verified.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   start       single-cycle load request (honoured in IDLE, DONE, ERR)
//   byte_in     stream data
//   byte_valid  byte_in is valid
//   byte_ready  loader accepts a byte this cycle
//   im_we       instruction-memory write strobe (one cycle per word)
//   im_addr     word address for the write
//   im_wdata    word to write
//   cpu_hold    high holds the core in reset (low only in DONE)
//   done        image loaded and verified
//   error       load failed (bad header or checksum)
module imem_loader #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_PAYLOAD,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    state_t              state_q, state_d;
    logic [15:0]         n_q, n_d;
    logic [ADDR_W:0]     idx_q, idx_d;
    logic [1:0]          bcnt_q, bcnt_d;
    logic [23:0]         asm_q, asm_d;
    logic [7:0]          csum_q, csum_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;

    logic                accept;
    logic [15:0]         n_new;
    logic [ADDR_W:0]     idx_inc;

    // Status outputs are pure decodes of the state register, so they carry
    // no combinational path from any input and follow the async reset.
    assign byte_ready = (state_q == S_HDR0) || (state_q == S_HDR1) ||
                        (state_q == S_PAYLOAD) || (state_q == S_CHECK);
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERR);
    assign cpu_hold   = (state_q != S_DONE);
    assign im_we      = we_q;
    assign im_addr    = addr_q;
    assign im_wdata   = wdata_q;

    assign accept  = byte_valid & byte_ready;
    assign n_new   = {byte_in, n_q[7:0]};
    assign idx_inc = idx_q + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            asm_q   <= '0;
            csum_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            asm_q   <= asm_d;
            csum_q  <= csum_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        csum_d  = csum_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_HDR0;
                    idx_d   = '0;
                    bcnt_d  = '0;
                    csum_d  = '0;
                end
            end
            S_HDR0: begin
                if (accept) begin
                    n_d     = {8'h00, byte_in};
                    state_d = S_HDR1;
                end
            end
            S_HDR1: begin
                if (accept) begin
                    n_d = n_new;
                    if (n_new == 16'd0 || {1'b0, n_new} > DEPTH_L) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (accept) begin
                    csum_d = csum_q ^ byte_in;
                    bcnt_d = bcnt_q + 2'd1;
                    case (bcnt_q)
                        2'd0: asm_d[7:0]   = byte_in;
                        2'd1: asm_d[15:8]  = byte_in;
                        2'd2: asm_d[23:16] = byte_in;
                        default: begin
                            // Fourth byte: the word is complete this edge.
                            wdata_d = {byte_in, asm_q};
                            addr_d  = idx_q[ADDR_W-1:0];
                            we_d    = 1'b1;
                            idx_d   = idx_inc;
                            if ({{(15-ADDR_W){1'b0}}, idx_inc} == n_q) begin
                                state_d = S_CHECK;
                            end
                        end
                    endcase
                end
            end
            S_CHECK: begin
                if (accept) begin
                    state_d = (byte_in == csum_q) ? S_DONE : S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader upstream of the single-cycle MIPS core. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes those words into the 4 KB instruction memory through a dedicated write port and holds the core in reset until the image has loaded and its checksum has verified. It is the only writer of instruction memory.

## Interface
- `DEPTH`, default 1024: instruction-memory size in words.
- `ADDR_W`, default 10: word-address width, `log2(DEPTH)`.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle load request.
- `byte_in`  in  8  stream data.
- `byte_valid`  in  1  `byte_in` is valid.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `im_we`  out  1  instruction-memory write strobe.
- `im_addr`  out  `ADDR_W`  word address for the write.
- `im_wdata`  out  32  word to write.
- `cpu_hold`  out  1  high holds the core in reset.
- `done`  out  1  image loaded and verified.
- `error`  out  1  load failed.

## Operation
- Stream format:
  - 2-byte word count N, LSB first.
  - 4N payload bytes; each word is sent LSB first, so byte k of a word lands in bits `[8k+7:8k]`.
  - 1 checksum byte, equal to the XOR of all 4N payload bytes (header excluded).
- A byte is accepted on any rising edge where `byte_valid & byte_ready`. Idle cycles between bytes are allowed.
- States:
  - IDLE: `byte_ready`=0. `start` goes to HDR0 and clears `done`, `error`, the checksum accumulator and the word index.
  - HDR0: `byte_ready`=1. On accept, latch `N[7:0]` and go to HDR1.
  - HDR1: `byte_ready`=1. On accept, latch `N[15:8]`. If N==0 or N>DEPTH, go to ERR; otherwise go to PAYLOAD.
  - PAYLOAD: `byte_ready`=1. On accept, shift the byte into the word assembler, XOR it into the checksum and increment the byte-in-word counter (2 bits, wraps).
    - On the 4th byte of a word: register `im_wdata` = the assembled word, `im_addr` = word index, and set `im_we` for the next cycle only. Then increment the word index.
    - After word N-1 is written, go to CHECK.
  - CHECK: `byte_ready`=1. On accept, go to DONE if the byte equals the checksum, else go to ERR.
  - DONE: `byte_ready`=0, `done`=1, `cpu_hold`=0. `start` goes to HDR0 (reload).
  - ERR: `byte_ready`=0, `error`=1, `cpu_hold`=1. `start` goes to HDR0.
- `start` is ignored in HDR0, HDR1, PAYLOAD and CHECK.
- `cpu_hold`:
  - It is 0 only in DONE.
  - Leaving DONE on `start` raises it on the same edge the state changes.
- Word index is `ADDR_W`+1 bits wide and compared against N (16 bits, zero-extended). Index never exceeds DEPTH because of the header check.
- Any bytes following the checksum byte are not accepted (`byte_ready`=0).

## Timing
- Reset (`rst`=0), effective immediately without waiting for a clock edge:
  - state = IDLE; `byte_ready`=0, `im_we`=0, `im_addr`=0, `im_wdata`=0, `cpu_hold`=1, `done`=0, `error`=0.
  - Internal counters and checksum are cleared.
- Reset mid-load aborts the load. The memory retains any words already written. `im_we` drops without waiting for a clock edge.
- All outputs are registered, with no combinational path from inputs to outputs.
- `start` to `byte_ready`=1: 1 cycle (the state changes on the edge where `start` is sampled high).
- 4th byte of a word accepted at edge t: `im_we`=1 for the cycle after edge t, with `im_addr`/`im_wdata` stable during that cycle. `im_we` returns to 0 at edge t+1 unless another word completes at edge t+1, which cannot occur (a word needs at least 4 edges).
- Maximum throughput is 1 byte per cycle. Minimum load time with no gaps is 2+4N+1 accept cycles.
- The last word's `im_we` occurs in the first cycle of CHECK. A checksum byte accepted on that same edge is legal.
- Checksum accepted at edge t: `done`/`error` and the `cpu_hold` update are visible after edge t.

## Test plan
- Happy path: `start`, then N=2 with bytes 02 00 | 01 00 01 3C | 00 00 00 00 | 3C, back-to-back. Required: `im_we` pulses with addr 0/data 0x3C010001 and addr 1/data 0x00000000; `done`=1; `cpu_hold`=0; `error`=0.
- Bad checksum: same stream with the final byte 3D. Required: both words written, then `error`=1, `cpu_hold`=1, `done`=0, `byte_ready`=0.
- Header bounds:
  - 00 00 → `error`=1 the cycle after the second byte, with no `im_we`.
  - 01 04 (N=1025) → `error`=1.
  - 00 04 (N=1024) → proceeds to PAYLOAD.
- Gapped stream: happy-path bytes with a random 0-5 idle cycles of `byte_valid`=0 between them. Required: results identical to the happy path, and exactly one `im_we` per word.
- Reset mid-PAYLOAD after 6 payload bytes: `rst`=0 asynchronously. Required: all outputs return to their reset values immediately and word 0 remains written. A subsequent `start` with a full stream completes with `done`=1.
- Reload from DONE: `start` raises `cpu_hold` the next cycle. `start` pulses during PAYLOAD are ignored.
